// File: rtl/rv_pkg.sv
// Shared RISC-V fetch-side definitions: word width, canonical NOP, PC step,
// the prefetch entry layout and a PC alignment helper.
package rv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // addi x0, x0, 0
  localparam word_t INST_NOP = 32'h0000_0013;
  localparam word_t PC_INC   = 32'd4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are forced to zero.
  function automatic word_t align_pc(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and flush. Push and pop may coincide even
// when full. The head entry is read straight from registered storage, so
// pop_data is valid whenever empty is low.
module fetch_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; count/empty gate every use of its contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues req/gnt/rvalid fetches under a
// credit limit (buffered + in-flight <= DEPTH), buffers returned words in a
// prefetch FIFO and presents one instruction per cycle downstream. A redirect
// empties the FIFO, retargets the PC and marks every in-flight response to be
// discarded on arrival.
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  word_t          pc;
  logic           run;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  outstanding_nxt;
  logic [CW-1:0]  kill_cnt;
  logic [CW-1:0]  kill_nxt;
  logic [CW:0]    credit_used;

  logic           grant;
  logic           rsp;
  logic           push;
  logic           pop;

  // Prefetch FIFO signals.
  fetch_entry_t   push_entry;
  fetch_entry_t   head;
  logic [63:0]    fifo_rd;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  // In-flight address queue signals.
  word_t          rsp_pc;
  logic [CW-1:0]  pcq_count;
  logic           pcq_full;
  logic           pcq_empty;

  // Request side: never in a redirect cycle, never beyond the credit limit.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req    = run && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = pc;
  assign grant       = imem_req && imem_gnt;

  // Response side: a response with nothing outstanding is ignored. Responses
  // are dropped while killing, and also the one landing in a redirect cycle.
  assign rsp  = imem_rvalid && (outstanding != '0);
  assign push = rsp && !redirect_valid && (kill_cnt == '0);

  // Downstream consumes the head unless stalled; a redirect overrides the pop.
  assign pop  = !fifo_empty && !stall && !redirect_valid;

  assign push_entry = '{pc: rsp_pc, inst: imem_rdata};
  assign head       = fetch_entry_t'(fifo_rd);
  assign inst_valid = !fifo_empty;
  assign inst_out   = inst_valid ? head.inst : INST_NOP;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .pop_data  (fifo_rd),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Addresses of granted requests, retired in order as responses arrive
  // (killed ones included), so the head is always the PC of the next response.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (pc),
    .pop       (rsp),
    .flush     (1'b0),
    .pop_data  (rsp_pc),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  // Next values of the in-flight and kill counters.
  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);
    kill_nxt        = kill_cnt;
    if (redirect_valid) begin
      // Every response still in flight after this cycle belongs to the
      // abandoned stream; kill_cnt already counts a subset of them.
      kill_nxt = outstanding - CW'(rsp);
    end else if (rsp && (kill_cnt != '0)) begin
      kill_nxt = kill_cnt - 1'b1;
    end
  end

  // Requests are held off until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Program counter: a redirect wins, otherwise step past each granted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
    end else if (grant) begin
      pc <= pc + PC_INC;
    end
  end

  // Credit and kill bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      kill_cnt    <= kill_nxt;
    end
  end

  // Protocol and bookkeeping sanity checks.
  a_rvalid_expected : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outstanding != '0));
  a_pcq_tracks : assert property (@(posedge clk) disable iff (!rst_n)
    (pcq_count == outstanding) && (pcq_empty == (outstanding == '0)));
  a_pcq_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(grant && pcq_full));
  a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));
  a_kill_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    kill_cnt <= outstanding);

endmodule
